// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, imem request/response, 2-entry prefetch FIFO, F/D register.
// Define FETCH_BUBBLE_CNT_EN to build the saturating decode bubble counter.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_F,
    input  logic        stall_D,
    input  logic        flush_D,
    input  logic        redirect_E,
    input  logic [31:0] target_E,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc_plus4_D,
    output logic        valid_D,
    output logic [31:0] bubble_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        run_q;
    logic [31:0] pc_f;
    logic [1:0]  out_cnt;
    logic [1:0]  drop_cnt;
    logic [1:0]  fifo_cnt;

    // PCs of in-flight requests, dropped ones included, in issue order
    logic [1:0][31:0] opc;
    logic             owr;
    logic             ord;

    logic [1:0][31:0] fpc;
    logic [1:0][31:0] fins;
    logic             fwr;
    logic             frd;

    logic        rsp;
    logic        keep;
    logic        have;
    logic        avail;
    logic        load;
    logic        pop;
    logic        push;
    logic        hs;
    logic [2:0]  used;
    logic [2:0]  cap;
    logic [31:0] rsp_pc;
    logic [31:0] hd_pc;
    logic [31:0] hd_ins;

    always_comb begin
        rsp    = imem_rvalid & (out_cnt != 2'd0);
        rsp_pc = opc[ord];
        keep   = rsp & (drop_cnt == 2'd0) & !redirect_E;
        have   = fifo_cnt != 2'd0;
        avail  = have | keep;
        load   = !flush_D & !redirect_E & !stall_D & avail;
        pop    = load & have;
        // An empty FIFO hands the response straight to decode
        push   = keep & !(load & !have);
        hd_pc  = have ? fpc[frd] : rsp_pc;
        hd_ins = have ? fins[frd] : imem_rdata;
        used   = {1'b0, out_cnt} + {1'b0, fifo_cnt};
        cap    = 3'd2 + {2'b00, load};
        imem_req  = run_q & !redirect_E & !stall_F & (used < cap);
        imem_addr = pc_f;
        hs     = imem_req & imem_gnt;
    end

    assign pc_plus4_D = pc_D + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            pc_f     <= RESET_PC;
            out_cnt  <= 2'd0;
            drop_cnt <= 2'd0;
            opc      <= '0;
            owr      <= 1'b0;
            ord      <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            out_cnt <= out_cnt - {1'b0, rsp} + {1'b0, hs};
            if (redirect_E) begin
                pc_f     <= target_E & 32'hFFFF_FFFC;
                drop_cnt <= out_cnt - {1'b0, rsp};
            end else begin
                if (hs) pc_f <= pc_f + 32'd4;
                if (rsp && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
            end
            if (hs) begin
                opc[owr] <= pc_f;
                owr      <= ~owr;
            end
            if (rsp) ord <= ~ord;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt <= 2'd0;
            fwr      <= 1'b0;
            frd      <= 1'b0;
            fpc      <= '0;
            fins     <= '0;
        end else if (redirect_E) begin
            fifo_cnt <= 2'd0;
            fwr      <= 1'b0;
            frd      <= 1'b0;
        end else begin
            if (push) begin
                fpc[fwr]  <= rsp_pc;
                fins[fwr] <= imem_rdata;
                fwr       <= ~fwr;
            end
            if (pop) frd <= ~frd;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_D <= 1'b0;
            instr_D <= NOP;
            pc_D    <= 32'd0;
        end else if (flush_D || redirect_E) begin
            valid_D <= 1'b0;
            instr_D <= NOP;
        end else if (!stall_D) begin
            if (load) begin
                valid_D <= 1'b1;
                instr_D <= hd_ins;
                pc_D    <= hd_pc;
            end else begin
                valid_D <= 1'b0;
                instr_D <= NOP;
            end
        end
    end

`ifdef FETCH_BUBBLE_CNT_EN
    logic        bubble;
    logic [31:0] bub_q;

    assign bubble = !flush_D & !redirect_E & !stall_D & !avail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_q <= 32'd0;
        end else if (bubble && bub_q != 32'hFFFF_FFFF) begin
            bub_q <= bub_q + 32'd1;
        end
    end

    assign bubble_cnt = bub_q;
`else
    assign bubble_cnt = 32'd0;
`endif

endmodule
